// File: rtl/smbus_event_rx.sv
// rtl/smbus_event_rx.sv - LTPI SMBus event receiver: frame-repeat dedup, peer forwarding, echo checking
module smbus_event_rx #(
  parameter int ECHO_TIMEOUT_FRAMES = 8,
  parameter int ERR_CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frm_valid_i,
  input  logic [3:0]           frm_event_i,
  input  logic                 echo_en,
  input  logic                 tx_event_stb_i,
  input  logic [3:0]           tx_event_i,
  output logic [3:0]           rx_event_o,
  output logic                 rx_event_stb_o,
  output logic                 echo_pending_o,
  output logic                 echo_ok_o,
  output logic                 echo_err_o,
  output logic                 echo_timeout_o,
  output logic                 invalid_evt_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [3:0] EVT_IDLE          = 4'h0;
  localparam logic [3:0] EVT_START         = 4'h1;
  localparam logic [3:0] EVT_DATA_0        = 4'h2;
  localparam logic [3:0] EVT_DATA_1        = 4'h3;
  localparam logic [3:0] EVT_BIT_RCV       = 4'h4;
  localparam logic [3:0] EVT_STOP          = 4'h5;
  localparam logic [3:0] EVT_STOP_RCV      = 4'h7;
  localparam logic [3:0] EVT_START_ECHO    = 4'h8;
  localparam logic [3:0] EVT_DATA_0_ECHO   = 4'h9;
  localparam logic [3:0] EVT_DATA_1_ECHO   = 4'hA;
  localparam logic [3:0] EVT_DATA_RCV_ECHO = 4'hB;
  localparam logic [3:0] EVT_STOP_ECHO     = 4'hC;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_ECHO = 1'b1;

  localparam logic [8:0] TIMEOUT = 9'(ECHO_TIMEOUT_FRAMES);

  logic [0:0]           state_q, state_d;
  logic [3:0]           last_q, last_d;
  logic [3:0]           expected_q, expected_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]           rx_event_q, rx_event_d;
  logic                 rx_stb_q, rx_stb_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic                 to_q, to_d;
  logic                 inv_q, inv_d;

  logic                 frm_is_peer, frm_is_echo, frm_is_idle;
  logic                 new_evt, new_peer, new_echo;
  logic                 tx_is_launch, launch;
  logic [3:0]           tx_echo_code;
  logic [8:0]           frame_cnt_inc;

  always_comb begin
    frm_is_idle  = (frm_event_i == EVT_IDLE);
    frm_is_peer  = (frm_event_i >= EVT_START) && (frm_event_i <= EVT_STOP_RCV);
    frm_is_echo  = (frm_event_i >= EVT_START_ECHO) && (frm_event_i <= EVT_STOP_ECHO);
    tx_is_launch = (tx_event_i >= EVT_START) && (tx_event_i <= EVT_STOP);
    case (tx_event_i)
      EVT_START:   tx_echo_code = EVT_START_ECHO;
      EVT_DATA_0:  tx_echo_code = EVT_DATA_0_ECHO;
      EVT_DATA_1:  tx_echo_code = EVT_DATA_1_ECHO;
      EVT_BIT_RCV: tx_echo_code = EVT_DATA_RCV_ECHO;
      default:     tx_echo_code = EVT_STOP_ECHO;
    endcase
  end

  // A repeat of the last valid code is the transmitter holding the event; only an idle frame re-arms it.
  always_comb begin
    new_evt  = frm_valid_i && (frm_is_peer || frm_is_echo) && (frm_event_i != last_q);
    new_peer = new_evt && frm_is_peer;
    new_echo = new_evt && frm_is_echo;
    last_d   = last_q;
    if (frm_valid_i && frm_is_idle) begin
      last_d = EVT_IDLE;
    end else if (new_evt) begin
      last_d = frm_event_i;
    end
    rx_stb_d   = new_peer;
    rx_event_d = new_peer ? frm_event_i : EVT_IDLE;
    inv_d      = frm_valid_i && !frm_is_idle && !frm_is_peer && !frm_is_echo;
  end

  always_comb begin
    launch        = echo_en && tx_event_stb_i && tx_is_launch;
    frame_cnt_inc = {1'b0, frame_cnt_q} + 9'd1;
    state_d       = state_q;
    expected_d    = expected_q;
    frame_cnt_d   = frame_cnt_q;
    ok_d          = 1'b0;
    err_d         = 1'b0;
    to_d          = 1'b0;
    if (!echo_en) begin
      state_d = ST_IDLE;
    end else begin
      if (state_q == ST_WAIT_ECHO) begin
        if (frm_valid_i) begin
          frame_cnt_d = frame_cnt_inc[7:0];
        end
        if (new_echo) begin
          ok_d    = (frm_event_i == expected_q);
          err_d   = (frm_event_i != expected_q);
          state_d = ST_IDLE;
        end else if (frm_valid_i && (frame_cnt_inc >= TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
        // Relaunch before the old echo resolved is an overrun, reported as a single error.
        if (launch && !ok_d) begin
          err_d = 1'b1;
          to_d  = 1'b0;
        end
      end else if (new_echo) begin
        err_d = 1'b1;
      end
      if (launch) begin
        expected_d  = tx_echo_code;
        frame_cnt_d = 8'd0;
        state_d     = ST_WAIT_ECHO;
      end
    end
    err_cnt_d = err_cnt_q;
    if ((err_d || to_d) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= EVT_IDLE;
      expected_q  <= EVT_IDLE;
      frame_cnt_q <= 8'd0;
      err_cnt_q   <= '0;
      rx_event_q  <= EVT_IDLE;
      rx_stb_q    <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      expected_q  <= expected_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rx_event_q  <= rx_event_d;
      rx_stb_q    <= rx_stb_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      to_q        <= to_d;
      inv_q       <= inv_d;
    end
  end

  assign rx_event_o     = rx_event_q;
  assign rx_event_stb_o = rx_stb_q;
  assign echo_pending_o = (state_q == ST_WAIT_ECHO) && echo_en;
  assign echo_ok_o      = ok_q;
  assign echo_err_o     = err_q;
  assign echo_timeout_o = to_q;
  assign invalid_evt_o  = inv_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_smbus_event_rx.sv
// tb/tb_smbus_event_rx.sv - vector table, corner sequences and random model comparison for smbus_event_rx
module tb_smbus_event_rx;

  localparam int TO = 8;

  localparam logic [3:0] IDL = 4'h0, S = 4'h1, D0 = 4'h2, D1 = 4'h3, BR = 4'h4, ST = 4'h5;
  localparam logic [3:0] SE = 4'h8, D0E = 4'h9, D1E = 4'hA, DRE = 4'hB, STE = 4'hC, BAD = 4'hF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frm_valid_i = 1'b0;
  logic [3:0] frm_event_i = 4'h0;
  logic       echo_en = 1'b1;
  logic       tx_event_stb_i = 1'b0;
  logic [3:0] tx_event_i = 4'h0;
  logic [3:0] rx_event_o;
  logic       rx_event_stb_o, echo_pending_o, echo_ok_o, echo_err_o, echo_timeout_o, invalid_evt_o;
  logic [7:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  smbus_event_rx #(.ECHO_TIMEOUT_FRAMES(TO), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .frm_valid_i(frm_valid_i), .frm_event_i(frm_event_i),
    .echo_en(echo_en), .tx_event_stb_i(tx_event_stb_i), .tx_event_i(tx_event_i),
    .rx_event_o(rx_event_o), .rx_event_stb_o(rx_event_stb_o), .echo_pending_o(echo_pending_o),
    .echo_ok_o(echo_ok_o), .echo_err_o(echo_err_o), .echo_timeout_o(echo_timeout_o),
    .invalid_evt_o(invalid_evt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fv;
    logic [3:0] ev;
    logic       en;
    logic       tx;
    logic [3:0] txe;
    logic       stb;
    logic [3:0] rxe;
    logic       ok;
    logic       err;
    logic       to;
    logic       inv;
    logic       pend;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [3:0] ev, input logic en, input logic tx, input logic [3:0] txe);
    frm_valid_i = fv; frm_event_i = ev; echo_en = en; tx_event_stb_i = tx; tx_event_i = txe;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, IDL, 1'b1, 1'b0, IDL);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic add(input logic fv, input logic [3:0] ev, input logic en, input logic tx, input logic [3:0] txe,
                     input logic stb, input logic [3:0] rxe, input logic ok, input logic err, input logic to,
                     input logic inv, input logic pend, input int cnt);
    vec_t v;
    v.fv = fv; v.ev = ev; v.en = en; v.tx = tx; v.txe = txe; v.stb = stb; v.rxe = rxe;
    v.ok = ok; v.err = err; v.to = to; v.inv = inv; v.pend = pend; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic stb, input logic [3:0] rxe, input logic ok, input logic err,
                         input logic to, input logic inv, input logic pend, input int cnt);
    chk({tag, ".rx_stb"}, int'(rx_event_stb_o), int'(stb));
    chk({tag, ".rx_event"}, int'(rx_event_o), int'(rxe));
    chk({tag, ".ok"}, int'(echo_ok_o), int'(ok));
    chk({tag, ".err"}, int'(echo_err_o), int'(err));
    chk({tag, ".timeout"}, int'(echo_timeout_o), int'(to));
    chk({tag, ".invalid"}, int'(invalid_evt_o), int'(inv));
    chk({tag, ".pending"}, int'(echo_pending_o), int'(pend));
    chk({tag, ".err_cnt"}, int'(err_cnt_o), cnt);
  endtask

  // Reference model state: event classes follow the code table, echo tracking counts frames since launch.
  logic [3:0] m_last;
  logic       m_wait;
  logic [3:0] m_exp;
  int         m_frames;
  int         m_err;

  function automatic bit m_peer(input logic [3:0] e);
    return e inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
  endfunction
  function automatic bit m_echo(input logic [3:0] e);
    return e inside {SE, D0E, D1E, DRE, STE};
  endfunction
  function automatic logic [3:0] m_map(input logic [3:0] e);
    logic [3:0] tbl [0:5];
    tbl[0] = IDL; tbl[1] = SE; tbl[2] = D0E; tbl[3] = D1E; tbl[4] = DRE; tbl[5] = STE;
    return tbl[e];
  endfunction

  task automatic model_cycle(output logic stb, output logic [3:0] rxe, output logic ok, output logic err,
                             output logic to, output logic inv, output logic pend);
    bit isnew;
    bit launch;
    stb = 0; rxe = IDL; ok = 0; err = 0; to = 0; inv = 0; isnew = 0;
    if (frm_valid_i) begin
      if (frm_event_i == IDL) m_last = IDL;
      else if (!m_peer(frm_event_i) && !m_echo(frm_event_i)) inv = 1;
      else if (frm_event_i != m_last) begin
        m_last = frm_event_i;
        isnew = 1;
      end
    end
    if (isnew && m_peer(frm_event_i)) begin
      stb = 1;
      rxe = frm_event_i;
    end
    launch = echo_en && tx_event_stb_i && (tx_event_i >= S) && (tx_event_i <= ST);
    if (!echo_en) begin
      m_wait = 0;
    end else begin
      if (m_wait) begin
        if (frm_valid_i) m_frames++;
        if (isnew && m_echo(frm_event_i)) begin
          if (frm_event_i == m_exp) ok = 1; else err = 1;
          m_wait = 0;
        end else if (frm_valid_i && m_frames >= TO) begin
          to = 1;
          m_wait = 0;
        end
        if (launch && !ok) begin
          err = 1;
          to = 0;
        end
      end else if (isnew && m_echo(frm_event_i)) begin
        err = 1;
      end
      if (launch) begin
        m_exp = m_map(tx_event_i);
        m_frames = 0;
        m_wait = 1;
      end
    end
    if ((err || to) && m_err < 255) m_err++;
    pend = m_wait && echo_en;
  endtask

  initial begin
    logic e_stb, e_ok, e_err, e_to, e_inv, e_pend;
    logic [3:0] e_rxe;
    int r;

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk_all("reset", 0, IDL, 0, 0, 0, 0, 0, 0);

    // fv ev en tx txe | stb rxe ok err to inv pend cnt
    add(1, S,   1, 0, IDL,  1, S,   0, 0, 0, 0, 0, 0);
    add(1, S,   1, 0, IDL,  0, IDL, 0, 0, 0, 0, 0, 0);
    add(1, IDL, 1, 0, IDL,  0, IDL, 0, 0, 0, 0, 0, 0);
    add(1, D1,  1, 0, IDL,  1, D1,  0, 0, 0, 0, 0, 0);
    add(0, IDL, 1, 0, IDL,  0, IDL, 0, 0, 0, 0, 0, 0);
    add(0, IDL, 1, 1, S,    0, IDL, 0, 0, 0, 0, 1, 0);
    add(1, IDL, 1, 0, IDL,  0, IDL, 0, 0, 0, 0, 1, 0);
    add(1, IDL, 1, 0, IDL,  0, IDL, 0, 0, 0, 0, 1, 0);
    add(1, SE,  1, 0, IDL,  0, IDL, 1, 0, 0, 0, 0, 0);
    add(0, IDL, 1, 1, D0,   0, IDL, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++) add(1, IDL, 1, 0, IDL, 0, IDL, 0, 0, 0, 0, 1, 0);
    add(1, IDL, 1, 0, IDL,  0, IDL, 0, 0, 1, 0, 0, 1);
    add(1, D0E, 1, 0, IDL,  0, IDL, 0, 1, 0, 0, 0, 2);
    add(1, IDL, 1, 1, D1,   0, IDL, 0, 0, 0, 0, 1, 2);
    add(1, D0E, 1, 0, IDL,  0, IDL, 0, 1, 0, 0, 0, 3);
    add(0, IDL, 1, 1, ST,   0, IDL, 0, 0, 0, 0, 1, 3);
    add(0, IDL, 1, 1, S,    0, IDL, 0, 1, 0, 0, 1, 4);
    add(1, SE,  1, 0, IDL,  0, IDL, 1, 0, 0, 0, 0, 4);
    add(1, BAD, 1, 0, IDL,  0, IDL, 0, 0, 0, 1, 0, 4);
    add(1, IDL, 0, 1, S,    0, IDL, 0, 0, 0, 0, 0, 4);
    add(1, SE,  0, 0, IDL,  0, IDL, 0, 0, 0, 0, 0, 4);
    add(1, IDL, 1, 0, IDL,  0, IDL, 0, 0, 0, 0, 0, 4);

    foreach (vecs[i]) begin
      drive(vecs[i].fv, vecs[i].ev, vecs[i].en, vecs[i].tx, vecs[i].txe);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].stb, vecs[i].rxe, vecs[i].ok, vecs[i].err,
              vecs[i].to, vecs[i].inv, vecs[i].pend, vecs[i].cnt);
    end

    // Match on the timeout frame: only ok.
    do_reset();
    drive(0, IDL, 1, 1, BR); step();
    for (int i = 0; i < TO - 1; i++) begin drive(1, IDL, 1, 0, IDL); step(); end
    drive(1, DRE, 1, 0, IDL); step();
    chk_all("match_on_timeout", 0, IDL, 1, 0, 0, 0, 0, 0);

    // Unexpected echo and launch in the same IDLE cycle.
    drive(1, STE, 1, 1, ST); step();
    chk_all("idle_echo_and_launch", 0, IDL, 0, 1, 0, 0, 1, 1);

    // Asynchronous reset in WAIT_ECHO clears everything before the next edge.
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 0, IDL, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    drive(1, STE, 1, 0, IDL); step();
    chk_all("after_abort", 0, IDL, 0, 1, 0, 0, 0, 1);

    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(0, IDL, 1, 1, S); step();
      for (int i = 0; i < TO; i++) begin drive(1, IDL, 1, 0, IDL); step(); end
    end
    chk("saturate.err_cnt", int'(err_cnt_o), 255);
    chk("saturate.timeout", int'(echo_timeout_o), 1);

    do_reset();
    m_last = IDL; m_wait = 0; m_exp = IDL; m_frames = 0; m_err = 0;
    for (int n = 0; n < 3000; n++) begin
      frm_valid_i = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 9);
      if (r < 5) frm_event_i = IDL;
      else if (r < 8) frm_event_i = 4'($urandom_range(1, 7));
      else if (r == 8) frm_event_i = 4'($urandom_range(8, 12));
      else frm_event_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) echo_en = ~echo_en;
      if (n % 500 == 0) echo_en = 1'b1;
      tx_event_stb_i = ($urandom_range(0, 19) == 0);
      tx_event_i = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
      model_cycle(e_stb, e_rxe, e_ok, e_err, e_to, e_inv, e_pend);
      step();
      chk_all($sformatf("rand%0d", n), e_stb, e_rxe, e_ok, e_err, e_to, e_inv, e_pend, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smbus_event_rx.md
Name: smbus_event_rx

Overview:
- Receive-side companion to the SMBus event/echo transmit logic in the LTPI management interface.
- Consumes the 4-bit SMBus event field extracted from each received operational frame.
- Removes frame-repeat duplicates, separates peer events from echo events, and forwards peer events as single-cycle pulses to the I2C target/controller logic.
- Checks that each locally launched event is echoed back by the remote side within a bounded number of frames.

Parameters:
- ECHO_TIMEOUT_FRAMES, 8, number of received frames allowed between a local launch and its echo (range 1..255).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- frm_valid_i  in  1  single-cycle strobe, one per received operational frame.
- frm_event_i  in  4  smbus_event_t field of that frame (ltpi_pkg encoding); sampled only when frm_valid_i=1.
- echo_en  in  1  echo checking enabled.
- tx_event_stb_i  in  1  single-cycle strobe: local side launched an event onto the link.
- tx_event_i  in  4  launched event (smbus_event_t); sampled only when tx_event_stb_i=1.
- rx_event_o  out  4  deduplicated peer event; idle when rx_event_stb_o=0.
- rx_event_stb_o  out  1  one-cycle pulse qualifying rx_event_o.
- echo_pending_o  out  1  high while waiting for an echo.
- echo_ok_o  out  1  pulse: matching echo received.
- echo_err_o  out  1  pulse: wrong, unexpected or overrun echo.
- echo_timeout_o  out  1  pulse: no echo within ECHO_TIMEOUT_FRAMES.
- invalid_evt_o  out  1  pulse: unencoded event code received.
- err_cnt_o  out  ERR_CNT_W  saturating count of echo_err_o and echo_timeout_o pulses.

Behaviour:
Reset values:
- All pulse outputs are 0.
- rx_event_o=idle, echo_pending_o=0, err_cnt_o=0.
- Internal last_event=idle, expected=idle, frame_cnt=0, state=IDLE.
- Reset asserted mid-operation aborts any pending echo silently; no pulse is produced.

Event classes (ltpi_pkg names):
- Peer: start, data_0, data_1, bit_rcv, stop, start_rcv, stop_rcv.
- Echo: start_echo, data_0_echo, data_1_echo, data_rcv_echo, stop_echo.
- Any other code except idle (e.g. 4'hF) is invalid.

Deduplication, evaluated on each frm_valid_i:
- frm_event_i=idle: last_event<=idle, no output.
- Invalid code: invalid_evt_o pulses next cycle; last_event is unchanged.
- Valid code equal to last_event: treated as a repeat (the transmitter holds an event for 1–2 frames) and dropped.
- Valid code different from last_event: a new event; last_event<=frm_event_i.
- Two identical back-to-back events are therefore only seen as distinct if an idle frame separates them; the transmitter guarantees this.

Peer path:
- A new peer event drives rx_event_o=event with rx_event_stb_o=1 for exactly one cycle.
- Latency is 1 clk after frm_valid_i.
- Peer events are forwarded regardless of echo_en.

Echo tracker FSM, states IDLE and WAIT_ECHO:

IDLE:
- On tx_event_stb_i with echo_en=1 and tx_event_i a peer launch code (start, data_0, data_1, bit_rcv, stop):
  - expected <= mapped echo: start->start_echo, data_0->data_0_echo, data_1->data_1_echo, bit_rcv->data_rcv_echo, stop->stop_echo.
  - frame_cnt <= 0; go to WAIT_ECHO.
- Any other tx code is ignored.
- A new echo event while in IDLE: echo_err_o pulses (unexpected echo).

WAIT_ECHO:
- echo_pending_o=1.
- Each frm_valid_i increments frame_cnt.
- New echo event equal to expected: echo_ok_o pulses, go to IDLE.
- New echo event not equal to expected: echo_err_o pulses, go to IDLE.
- No echo and frame_cnt reaches ECHO_TIMEOUT_FRAMES on a frm_valid_i: echo_timeout_o pulses, go to IDLE.
- Match and timeout on the same frame: the match wins, so only echo_ok_o pulses.
- New tx_event_stb_i while in WAIT_ECHO:
  - Any echo arriving in the same cycle is first judged against the old expected.
  - Unless that echo matched, echo_err_o pulses (overrun).
  - The new expected is then loaded, frame_cnt <= 0, and the FSM stays in WAIT_ECHO.

echo_en=0:
- The FSM is forced to IDLE and echo_pending_o=0.
- Echo events are dropped with no pulse; tx strobes are ignored.
- Dropping echo_en while in WAIT_ECHO aborts silently.

Timing and counting:
- All echo pulses occur 1 clk after the causing strobe.
- err_cnt_o increments by 1 per cycle in which echo_err_o or echo_timeout_o is 1, and saturates at all-ones.

Test Plan:
1. Peer event with repeat: frames start, start, idle, data_1 -> rx_event_stb_o pulses exactly twice (start, data_1); each pulse 1 clk after its frm_valid_i.
2. Echo OK: echo_en=1, tx start; 2 frames later frame start_echo -> echo_pending_o high for 2 frames, then echo_ok_o pulses once; err_cnt_o=0.
3. Echo timeout: tx data_0, then 8 idle frames -> echo_timeout_o pulses on the 8th frame, err_cnt_o=1; a late data_0_echo then gives echo_err_o and err_cnt_o=2.
4. Mismatch and overrun:
   - tx data_1, then frame data_0_echo -> echo_err_o.
   - tx stop, then tx start before any echo -> echo_err_o (overrun); subsequent start_echo -> echo_ok_o.
5. Invalid and disable:
   - Frame 4'hF -> invalid_evt_o, no rx strobe.
   - echo_en=0 with tx start plus frame start_echo -> no echo pulses, echo_pending_o=0.
6. Reset mid-wait and saturation:
   - Async reset during WAIT_ECHO -> all outputs at reset values immediately.
   - 300 forced timeouts -> err_cnt_o holds 255.
